instr_dispatch_ctrl: RTL and testbench
======================================

Name: instr_dispatch_ctrl

Overview:
- Sequencer between the 13-bit instruction FIFO and the NLP execution engine.
- Pops instructions from the FIFO, decodes the 3-bit opcode, and issues compute ops to the engine over a valid/ready handshake.
- Tracks in-flight ops, implements WAIT (barrier) and HALT, and flags illegal opcodes.

Parameters:
- MAX_OUTSTANDING, 4: maximum issued-but-not-done ops; issue stalls at this limit (must be ≥1).
- OUT_W, 3: width of the outstanding counter; must hold MAX_OUTSTANDING.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; leaves IDLE or HALTED.
- busy  out  1  high when state is not IDLE and not HALTED.
- halted  out  1  high in HALTED.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  FIFO pop request.
- fifo_dout  in  13  FIFO registered output; valid the cycle after the pop.
- exec_valid  out  1  op offered to the engine.
- exec_ready  in  1  engine accepts the op.
- exec_op  out  3  opcode of the offered op.
- exec_arg  out  10  operand field of the offered op.
- exec_done  in  1  single-cycle pulse per completed op.
- outstanding  out  OUT_W  ops in flight.
- instr_count  out  16  instructions consumed; wraps.
- err_illegal  out  1  sticky illegal-opcode flag.

Behaviour:
- Reset: state IDLE. All outputs 0, instruction register 0.
- Instruction format: [12:10] opcode, [9:0] arg.
- Opcodes:
  - 000 NOP: consumed, not issued.
  - 001 LOAD, 010 MATMUL, 011 SOFTMAX, 100 STORE: issued to the engine.
  - 101 WAIT: barrier.
  - 110 HALT.
  - 111 illegal.
- FSM states: IDLE, FETCH, DECODE, ISSUE, BARRIER, HALTED.
- IDLE: on start, go to FETCH. No other inputs are sampled.
- FETCH: fifo_rd_en = !fifo_empty. If the FIFO is not empty, go to DECODE; otherwise stay (no pop while empty).
- fifo_rd_en is combinational from state and fifo_empty. It is asserted for exactly one cycle per instruction.
- DECODE:
  - Latch fifo_dout into the instruction register.
  - instr_count +1 for every opcode.
  - Next state: compute op → ISSUE; NOP → FETCH; WAIT → BARRIER; HALT → HALTED.
  - Illegal opcode: set err_illegal, discard the instruction, go to FETCH.
- ISSUE:
  - exec_op and exec_arg are driven from the instruction register.
  - exec_valid = (outstanding < MAX_OUTSTANDING).
  - On exec_valid && exec_ready, go to FETCH.
  - Once asserted, exec_valid and its payload stay stable until accepted. This holds because outstanding never increases while in ISSUE.
- Latency: pop in FETCH at cycle N → exec_valid at N+2 when not stalled. Back-to-back accepted ops issue every 3 cycles.
- BARRIER: stay while outstanding != 0. When outstanding == 0, go to FETCH the next cycle.
- HALTED: halted = 1, no pops. On start, go to FETCH.
- start is ignored in every state except IDLE and HALTED.
- Outstanding counter:
  - +1 on accepted issue; -1 on exec_done.
  - Accept and done in the same cycle: unchanged.
  - exec_done while outstanding == 0: ignored, no underflow.
  - Never exceeds MAX_OUTSTANDING.
- err_illegal clears only on reset.
- Reset mid-operation: returns immediately to IDLE with all counters and flags cleared.
  - An in-flight exec_valid drops.
  - A FIFO word already popped is lost; the system owner resets the FIFO together with this block.

Optional Feature:
- Macro: DISPATCH_PERF_EN.
- When defined, adds outputs stall_cycles[15:0] and barrier_cycles[15:0].
  - stall_cycles: +1 every ISSUE cycle with exec_valid low or exec_ready low.
  - barrier_cycles: +1 every BARRIER cycle with outstanding != 0.
  - Both saturate at 16'hFFFF and clear on reset.
- When undefined, these ports and registers do not exist. All other behaviour is identical.

Test Plan:
- Reset, FIFO holds {001_0000000101}, pulse start, exec_ready=1 → fifo_rd_en high 1 cycle; 2 cycles later exec_valid=1, exec_op=1, exec_arg=5; outstanding=1; instr_count=1.
- MAX_OUTSTANDING=4, 5 MATMULs queued, no exec_done → exactly 4 accepted; 5th held with exec_valid=0; pulse exec_done → 5th issues; outstanding returns to 4.
- Sequence LOAD, WAIT, STORE with exec_done delayed 10 cycles → STORE not popped until outstanding=0; then STORE issues; busy=1 throughout.
- Sequence HALT, SOFTMAX → halted=1, busy=0, FIFO untouched; start pulse → SOFTMAX issues; halted=0.
- Opcode 111 then NOP then LOAD → err_illegal=1 (sticky); only LOAD reaches the engine; instr_count=3. Simultaneous accept+done at outstanding=2 → stays 2. exec_done at outstanding=0 → stays 0.
- rst_n low while in ISSUE with exec_valid=1 → exec_valid, outstanding, instr_count, err_illegal all 0 immediately; state IDLE. With DISPATCH_PERF_EN: 3 ready-low cycles in ISSUE → stall_cycles=3.

Source files
------------

// File: rtl/instr_dispatch_ctrl.sv
// Instruction dispatch sequencer: pops 13-bit words from the instruction FIFO,
// decodes them and issues compute ops to the engine. Optional counters: DISPATCH_PERF_EN.
module instr_dispatch_ctrl #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int OUT_W           = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             halted,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [12:0]      fifo_dout,
    output logic             exec_valid,
    input  logic             exec_ready,
    output logic [2:0]       exec_op,
    output logic [9:0]       exec_arg,
    input  logic             exec_done,
    output logic [OUT_W-1:0] outstanding,
    output logic [15:0]      instr_count,
    output logic             err_illegal
`ifdef DISPATCH_PERF_EN
    ,
    output logic [15:0]      stall_cycles,
    output logic [15:0]      barrier_cycles
`endif
);

    localparam logic [OUT_W-1:0] MAX_Q = OUT_W'(MAX_OUTSTANDING);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_BARRIER,
        S_HALTED
    } state_t;

    state_t           state_q;
    logic [12:0]      instr_q;
    logic [OUT_W-1:0] out_q;
    logic [OUT_W-1:0] out_d;
    logic [15:0]      count_q;
    logic             err_q;
    logic             issue_fire;
    logic             done_eff;

    assign fifo_rd_en  = (state_q == S_FETCH) && !fifo_empty;
    assign exec_valid  = (state_q == S_ISSUE) && (out_q < MAX_Q);
    assign exec_op     = instr_q[12:10];
    assign exec_arg    = instr_q[9:0];
    assign busy        = (state_q != S_IDLE) && (state_q != S_HALTED);
    assign halted      = (state_q == S_HALTED);
    assign outstanding = out_q;
    assign instr_count = count_q;
    assign err_illegal = err_q;

    assign issue_fire = exec_valid && exec_ready;
    // A done pulse with nothing in flight is spurious and must not underflow.
    assign done_eff   = exec_done && (out_q != '0);

    always_comb begin
        out_d = out_q;
        if (issue_fire && !done_eff) begin
            out_d = out_q + 1'b1;
        end else if (!issue_fire && done_eff) begin
            out_d = out_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            instr_q <= '0;
            out_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            out_q <= out_d;
            case (state_q)
                S_IDLE: begin
                    if (start) state_q <= S_FETCH;
                end
                S_FETCH: begin
                    if (!fifo_empty) state_q <= S_DECODE;
                end
                S_DECODE: begin
                    count_q <= count_q + 16'd1;
                    case (fifo_dout[12:10])
                        3'b000: begin
                            instr_q <= fifo_dout;
                            state_q <= S_FETCH;
                        end
                        3'b001, 3'b010, 3'b011, 3'b100: begin
                            instr_q <= fifo_dout;
                            state_q <= S_ISSUE;
                        end
                        3'b101: begin
                            instr_q <= fifo_dout;
                            state_q <= S_BARRIER;
                        end
                        3'b110: begin
                            instr_q <= fifo_dout;
                            state_q <= S_HALTED;
                        end
                        default: begin
                            err_q   <= 1'b1;
                            state_q <= S_FETCH;
                        end
                    endcase
                end
                S_ISSUE: begin
                    if (issue_fire) state_q <= S_FETCH;
                end
                S_BARRIER: begin
                    if (out_q == '0) state_q <= S_FETCH;
                end
                S_HALTED: begin
                    if (start) state_q <= S_FETCH;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef DISPATCH_PERF_EN
    logic [15:0] stall_q;
    logic [15:0] barrier_q;

    assign stall_cycles   = stall_q;
    assign barrier_cycles = barrier_q;

    // Both counters saturate rather than wrap so long stalls stay visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q   <= '0;
            barrier_q <= '0;
        end else begin
            if ((state_q == S_ISSUE) && !issue_fire && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'd1;
            end
            if ((state_q == S_BARRIER) && (out_q != '0) && (barrier_q != 16'hFFFF)) begin
                barrier_q <= barrier_q + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_dispatch_ctrl.sv
// Self-checking bench for instr_dispatch_ctrl: per-opcode vector table plus
// directed multi-cycle sequences (stall limit, barrier, halt, illegal, reset).
module tb_instr_dispatch_ctrl;

    localparam int MAXO = 4;
    localparam int OW   = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy;
    logic          halted;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [12:0]   fifo_dout;
    logic          exec_valid;
    logic          exec_ready = 1'b0;
    logic [2:0]    exec_op;
    logic [9:0]    exec_arg;
    logic          exec_done = 1'b0;
    logic [OW-1:0] outstanding;
    logic [15:0]   instr_count;
    logic          err_illegal;
`ifdef DISPATCH_PERF_EN
    logic [15:0]   stall_cycles;
    logic [15:0]   barrier_cycles;
`endif

    int checks = 0;
    int errors = 0;

    logic [12:0] fifo_q[$];
    logic [2:0]  log_op[$];
    logic [9:0]  log_arg[$];

    instr_dispatch_ctrl #(.MAX_OUTSTANDING(MAXO), .OUT_W(OW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .halted(halted),
        .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
        .exec_valid(exec_valid), .exec_ready(exec_ready), .exec_op(exec_op),
        .exec_arg(exec_arg), .exec_done(exec_done), .outstanding(outstanding),
        .instr_count(instr_count), .err_illegal(err_illegal)
`ifdef DISPATCH_PERF_EN
        , .stall_cycles(stall_cycles), .barrier_cycles(barrier_cycles)
`endif
    );

    always #5 clk = ~clk;

    assign fifo_empty = (fifo_q.size() == 0);

    // Registered-output FIFO model: the popped word appears the cycle after rd_en.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) fifo_dout <= '0;
        else if (fifo_rd_en && fifo_q.size() != 0) fifo_dout <= fifo_q.pop_front();
    end

    always @(posedge clk) begin
        if (rst_n && exec_valid && exec_ready) begin
            log_op.push_back(exec_op);
            log_arg.push_back(exec_arg);
        end
    end

    typedef struct {
        logic [12:0] instr;
        logic        exp_issue;
        logic        exp_busy;
        logic        exp_halted;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        start      = 1'b0;
        exec_done  = 1'b0;
        exec_ready = 1'b0;
        fifo_q.delete();
        log_op.delete();
        log_arg.delete();
        step(2);
        rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic pulse_done();
        exec_done = 1'b1;
        step(1);
        exec_done = 1'b0;
    endtask

    task automatic wait_log(input int n, input string name);
        for (int i = 0; i < 40 && log_op.size() < n; i++) step(1);
        chk(name, 32'(log_op.size()), n);
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 40 && !exec_valid; i++) step(1);
        chk(name, 32'(exec_valid), 1);
    endtask

    initial begin
        vecs[0] = '{{3'b000, 10'd17},  1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{{3'b001, 10'd5},   1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{{3'b010, 10'h3FF}, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{{3'b011, 10'd0},   1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{{3'b100, 10'h155}, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{{3'b101, 10'd9},   1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{{3'b110, 10'd1},   1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{{3'b111, 10'd2},   1'b0, 1'b1, 1'b0, 1'b1};

        // Reset state
        do_reset();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_rd_en", 32'(fifo_rd_en), 0);
        chk("rst_valid", 32'(exec_valid), 0);
        chk("rst_out", 32'(outstanding), 0);
        chk("rst_count", 32'(instr_count), 0);
        chk("rst_err", 32'(err_illegal), 0);

        // One instruction per opcode from a fresh reset
        for (int v = 0; v < 8; v++) begin
            do_reset();
            exec_ready = 1'b1;
            fifo_q.push_back(vecs[v].instr);
            pulse_start();
            step(6);
            chk($sformatf("v%0d_issued", v), 32'(log_op.size()), 32'(vecs[v].exp_issue));
            if (vecs[v].exp_issue && log_op.size() > 0) begin
                chk($sformatf("v%0d_op", v), 32'(log_op[0]), 32'(vecs[v].instr[12:10]));
                chk($sformatf("v%0d_arg", v), 32'(log_arg[0]), 32'(vecs[v].instr[9:0]));
            end
            chk($sformatf("v%0d_out", v), 32'(outstanding), 32'(vecs[v].exp_issue));
            chk($sformatf("v%0d_busy", v), 32'(busy), 32'(vecs[v].exp_busy));
            chk($sformatf("v%0d_halted", v), 32'(halted), 32'(vecs[v].exp_halted));
            chk($sformatf("v%0d_err", v), 32'(err_illegal), 32'(vecs[v].exp_err));
            chk($sformatf("v%0d_count", v), 32'(instr_count), 1);
        end

        // First-op latency: pop, then exec_valid two cycles later
        do_reset();
        exec_ready = 1'b1;
        fifo_q.push_back({3'b001, 10'd5});
        pulse_start();
        chk("lat_rd_en", 32'(fifo_rd_en), 1);
        step(1);
        chk("lat_rd_en_once", 32'(fifo_rd_en), 0);
        chk("lat_valid_early", 32'(exec_valid), 0);
        step(1);
        chk("lat_valid", 32'(exec_valid), 1);
        chk("lat_op", 32'(exec_op), 1);
        chk("lat_arg", 32'(exec_arg), 5);
        chk("lat_count", 32'(instr_count), 1);
        step(1);
        chk("lat_out", 32'(outstanding), 1);

        // Outstanding limit: 5 MATMULs, no done
        do_reset();
        exec_ready = 1'b1;
        for (int k = 1; k <= 5; k++) fifo_q.push_back({3'b010, 10'(k)});
        pulse_start();
        step(25);
        chk("lim_accepted", 32'(log_op.size()), 4);
        chk("lim_out", 32'(outstanding), 4);
        chk("lim_valid_low", 32'(exec_valid), 0);
        chk("lim_held_arg", 32'(exec_arg), 5);
        chk("lim_busy", 32'(busy), 1);
        pulse_done();
        chk("lim_valid_after_done", 32'(exec_valid), 1);
        step(1);
        chk("lim_accepted5", 32'(log_op.size()), 5);
        if (log_arg.size() == 5) chk("lim_arg5", 32'(log_arg[4]), 5);
        chk("lim_out_back", 32'(outstanding), 4);

        // Barrier: LOAD, WAIT, STORE with delayed done
        do_reset();
        exec_ready = 1'b1;
        fifo_q.push_back({3'b001, 10'd7});
        fifo_q.push_back({3'b101, 10'd0});
        fifo_q.push_back({3'b100, 10'd9});
        pulse_start();
        begin
            int busy_low = 0;
            for (int i = 0; i < 12; i++) begin
                if (!busy) busy_low++;
                step(1);
            end
            chk("bar_store_not_popped", 32'(fifo_q.size()), 1);
            chk("bar_out", 32'(outstanding), 1);
            chk("bar_issued", 32'(log_op.size()), 1);
`ifdef DISPATCH_PERF_EN
            chk("bar_perf_nonzero", 32'(barrier_cycles != 0), 1);
`endif
            pulse_done();
            for (int i = 0; i < 40 && log_op.size() < 2; i++) begin
                if (!busy) busy_low++;
                step(1);
            end
            chk("bar_store_issued", 32'(log_op.size()), 2);
            chk("bar_busy_throughout", 32'(busy_low), 0);
        end
        if (log_op.size() == 2) begin
            chk("bar_store_op", 32'(log_op[1]), 4);
            chk("bar_store_arg", 32'(log_arg[1]), 9);
        end

        // HALT then SOFTMAX
        do_reset();
        exec_ready = 1'b1;
        fifo_q.push_back({3'b110, 10'd0});
        fifo_q.push_back({3'b011, 10'd3});
        pulse_start();
        step(6);
        chk("halt_halted", 32'(halted), 1);
        chk("halt_busy", 32'(busy), 0);
        chk("halt_fifo", 32'(fifo_q.size()), 1);
        chk("halt_rd_en", 32'(fifo_rd_en), 0);
        pulse_start();
        chk("halt_resume", 32'(halted), 0);
        wait_log(1, "halt_softmax_issued");
        if (log_op.size() > 0) begin
            chk("halt_op", 32'(log_op[0]), 3);
            chk("halt_arg", 32'(log_arg[0]), 3);
        end
        chk("halt_count", 32'(instr_count), 2);

        // Illegal, NOP, LOAD; then accept+done and spurious done
        do_reset();
        exec_ready = 1'b1;
        fifo_q.push_back({3'b111, 10'd1});
        fifo_q.push_back({3'b000, 10'd2});
        fifo_q.push_back({3'b001, 10'h2A});
        pulse_start();
        wait_log(1, "ill_load_issued");
        step(4);
        chk("ill_only_load", 32'(log_op.size()), 1);
        if (log_op.size() > 0) begin
            chk("ill_op", 32'(log_op[0]), 1);
            chk("ill_arg", 32'(log_arg[0]), 32'h2A);
        end
        chk("ill_err", 32'(err_illegal), 1);
        chk("ill_count", 32'(instr_count), 3);
        fifo_q.push_back({3'b001, 10'd1});
        wait_log(2, "ill_second_load");
        chk("ill_out2", 32'(outstanding), 2);
        fifo_q.push_back({3'b001, 10'd2});
        wait_valid("ill_third_valid");
        exec_done = 1'b1;
        step(1);
        exec_done = 1'b0;
        chk("ill_accept_done_same", 32'(outstanding), 2);
        pulse_done();
        pulse_done();
        chk("ill_out_zero", 32'(outstanding), 0);
        pulse_done();
        chk("ill_no_underflow", 32'(outstanding), 0);
        chk("ill_err_sticky", 32'(err_illegal), 1);

        // Reset mid-ISSUE with exec_valid high
        do_reset();
        exec_ready = 1'b1;
        fifo_q.push_back({3'b111, 10'd0});
        fifo_q.push_back({3'b001, 10'd4});
        fifo_q.push_back({3'b010, 10'd6});
        pulse_start();
        wait_log(1, "mid_first_issue");
        exec_ready = 1'b0;
        wait_valid("mid_valid");
        step(3);
        chk("mid_valid_held", 32'(exec_valid), 1);
        chk("mid_held_op", 32'(exec_op), 2);
        chk("mid_count", 32'(instr_count), 3);
`ifdef DISPATCH_PERF_EN
        chk("mid_stall_cycles", 32'(stall_cycles), 3);
`endif
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(exec_valid), 0);
        chk("mid_rst_out", 32'(outstanding), 0);
        chk("mid_rst_count", 32'(instr_count), 0);
        chk("mid_rst_err", 32'(err_illegal), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_halted", 32'(halted), 0);
`ifdef DISPATCH_PERF_EN
        chk("mid_rst_stall", 32'(stall_cycles), 0);
`endif
        step(2);
        rst_n = 1'b1;
        step(1);
        chk("mid_idle_rd_en", 32'(fifo_rd_en), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
